// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (default fp16) for the MAC datapath.
// RNE rounding, DAZ/FTZ, IEEE special cases, and a valid/ready handshake with per-stage stall.
module fp_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   c,
    output logic [3:0]             flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EZERO = '0;

    logic adv1, adv2, adv3;
    logic v1_q, v2_q, v3_q;

    assign adv3      = ~v3_q | out_ready;
    assign adv2      = ~v2_q | adv3;
    assign adv1      = ~v1_q | adv2;
    assign in_ready  = adv1;
    assign out_valid = v3_q;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             za, zb, ia, ib, na, nb;
    logic signed [EW-1:0] ea_x, eb_x, e1_d;
    logic [PW-1:0]    p1_d;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    // Subnormals collapse to zero here, so only exponent zero matters.
    assign za   = (ea == '0);
    assign zb   = (eb == '0);
    assign ia   = (&ea) & (fa == '0);
    assign ib   = (&eb) & (fb == '0);
    assign na   = (&ea) & (|fa);
    assign nb   = (&eb) & (|fb);
    assign ea_x = {2'b00, ea};
    assign eb_x = {2'b00, eb};
    assign e1_d = ea_x + eb_x - BIAS;
    assign p1_d = PW'({1'b1, fa}) * PW'({1'b1, fb});

    logic                 s1_q, nan1_q, inv1_q, inf1_q, zero1_q;
    logic signed [EW-1:0] e1_q;
    logic [PW-1:0]        p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            s1_q    <= 1'b0;
            nan1_q  <= 1'b0;
            inv1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
            e1_q    <= '0;
            p1_q    <= '0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_q    <= sa ^ sb;
                nan1_q  <= na | nb | (ia & zb) | (ib & za);
                inv1_q  <= (ia & zb) | (ib & za);
                inf1_q  <= ia | ib;
                zero1_q <= za | zb;
                e1_q    <= e1_d;
                p1_q    <= p1_d;
            end
        end
    end

    logic [PW-1:0]        sh;
    logic [MAN_W:0]       mant;
    logic                 grd, stk, inc;
    logic [MAN_W+1:0]     mr;
    logic signed [EW-1:0] e2_d;
    logic [MAN_W-1:0]     f2_d;

    assign sh   = p1_q[PW-1] ? p1_q : {p1_q[PW-2:0], 1'b0};
    assign mant = sh[PW-1 -: MAN_W+1];
    assign grd  = sh[MAN_W];
    assign stk  = |sh[MAN_W-1:0];
    assign inc  = grd & (stk | mant[0]);
    assign mr   = {1'b0, mant} + (MAN_W+2)'(inc);
    assign e2_d = e1_q + EW'(p1_q[PW-1]) + EW'(mr[MAN_W+1]);
    // A rounding carry leaves 10.00..0, whose shifted fraction is all zero.
    assign f2_d = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];

    logic                 s2_q, nan2_q, inv2_q, inf2_q, zero2_q, ix2_q;
    logic signed [EW-1:0] e2_q;
    logic [MAN_W-1:0]     f2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            s2_q    <= 1'b0;
            nan2_q  <= 1'b0;
            inv2_q  <= 1'b0;
            inf2_q  <= 1'b0;
            zero2_q <= 1'b0;
            ix2_q   <= 1'b0;
            e2_q    <= '0;
            f2_q    <= '0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_q    <= s1_q;
                nan2_q  <= nan1_q;
                inv2_q  <= inv1_q;
                inf2_q  <= inf1_q;
                zero2_q <= zero1_q;
                ix2_q   <= grd | stk;
                e2_q    <= e2_d;
                f2_q    <= f2_d;
            end
        end
    end

    logic [W-1:0] c_d, c_q;
    logic [3:0]   fl_d, fl_q;

    always_comb begin
        c_d  = '0;
        fl_d = '0;
        if (nan2_q) begin
            c_d  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            fl_d = {inv2_q, 3'b000};
        end else if (inf2_q) begin
            c_d = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero2_q) begin
            c_d = {s2_q, {(W-1){1'b0}}};
        end else if (e2_q >= EMAX) begin
            c_d  = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            fl_d = 4'b0101;
        end else if (e2_q <= EZERO) begin
            c_d  = {s2_q, {(W-1){1'b0}}};
            fl_d = 4'b0011;
        end else begin
            c_d  = {s2_q, e2_q[EXP_W-1:0], f2_q};
            fl_d = {3'b000, ix2_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q <= 1'b0;
            c_q  <= '0;
            fl_q <= '0;
        end else if (adv3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                c_q  <= c_d;
                fl_q <= fl_d;
            end
        end
    end

    assign c     = c_q;
    assign flags = fl_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Testbench for fp_mul_pipe (fp16): directed vectors, stall/ordering, reset
// mid-flight and randomized traffic against an integer reference model.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] c;
    logic [3:0]  flags;

    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    logic [19:0] sb[$];
    logic [19:0] want;
    logic [19:0] held;
    bit          hold_seen = 0;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c(c),
        .flags(flags)
    );

    // Independent reference: integer mantissa product, remainder-based RNE.
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y);
        int  ex, ey, e, p, k, q, rem, half;
        bit  zx, zy, ix, iy, nx, ny, s, inx;
        logic [15:0] r;
        s  = x[15] ^ y[15];
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 31) && (x[9:0] == 0);
        iy = (ey == 31) && (y[9:0] == 0);
        nx = (ex == 31) && (x[9:0] != 0);
        ny = (ey == 31) && (y[9:0] != 0);
        if (nx || ny || (ix && zy) || (iy && zx))
            return {16'h7E00, ((ix && zy) || (iy && zx)) ? 4'b1000 : 4'b0000};
        if (ix || iy) return {s, 15'h7C00, 4'b0000};
        if (zx || zy) return {s, 15'h0000, 4'b0000};
        p = (1024 + int'(x[9:0])) * (1024 + int'(y[9:0]));
        e = ex + ey - 15;
        k = 10;
        if (p >= (1 << 21)) begin
            k = 11;
            e++;
        end
        q    = p >> k;
        rem  = p - (q << k);
        half = 1 << (k - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        if (q >= 2048) begin
            q = q >> 1;
            e++;
        end
        if (e >= 31) return {s, 15'h7C00, 4'b0101};
        if (e <= 0) return {s, 15'h0000, 4'b0011};
        r = {s, e[4:0], q[9:0]};
        return {r, 3'b000, inx};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_seen = 0;
        end else begin
            if (hold_seen) begin
                checks++;
                if (out_valid !== 1'b1 || {c, flags} !== held) begin
                    errors++;
                    $display("FAIL hold: v=%b c/flags=%h required v=1 %h", out_valid, {c, flags}, held);
                end
            end
            hold_seen = 0;
            if (out_valid && out_ready) begin
                checks++;
                pops++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: c=%h flags=%b with nothing pending", c, flags);
                end else begin
                    want = sb.pop_front();
                    if ({c, flags} !== want) begin
                        errors++;
                        $display("FAIL result: c=%h flags=%b required c=%h flags=%b", c, flags, want[19:4], want[3:0]);
                    end
                end
            end else if (out_valid) begin
                hold_seen = 1;
                held = {c, flags};
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [19:0] e);
        int n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL extra_output: out_valid=%b required 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: out_valid=%b required 0", out_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 16'h0 || flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b v=%b c=%h f=%b required 1 0 0000 0000", in_ready, out_valid, c, flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency(input logic [15:0] x, input logic [15:0] y, input logic [19:0] e);
        int n = 0;
        out_ready = 1'b1;
        send(x, y, e);
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL latency: %0d cycles required 3", n);
        end
        drain();
    endtask

    task automatic test_vectors(input logic [15:0] xs[3], input logic [15:0] ys[3], input logic [19:0] es[3]);
        int p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(xs[i], ys[i], es[i]);
        in_valid = 1'b0;
        drain();
        checks++;
        if (pops - p0 !== 3) begin
            errors++;
            $display("FAIL vector_count: %0d outputs required 3", pops - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ys[6] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600};
        int idx = 0;
        int p0 = pops;
        bit acc;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 16'h3C00;
        b = ys[0];
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back({ys[idx], 4'b0000});
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                b = ys[idx];
            end
        end
        @(negedge clk);
        checks++;
        if (idx !== 3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: accepted=%0d in_ready=%b required 3 0", idx, in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = idx; i < 6; i++) send(16'h3C00, ys[i], {ys[i], 4'b0000});
        in_valid = 1'b0;
        drain();
        checks++;
        if (pops - p0 !== 6) begin
            errors++;
            $display("FAIL stall_count: %0d outputs required 6", pops - p0);
        end
    endtask

    task automatic test_reset_flight();
        int bad = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'h4000, 16'h4000, {16'h4400, 4'b0000});
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: out_valid=%b required 0", out_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_quiet: out_valid high %0d cycles required 0", bad);
        end
        @(posedge clk);
        #1;
        test_latency(16'h3C00, 16'h3C00, {16'h3C00, 4'b0000});
    endtask

    function automatic logic [15:0] rand_op();
        int r = $urandom_range(0, 9);
        logic [4:0] e;
        e = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(6, 24));
        return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
    endfunction

    task automatic test_random();
        bit done = 0;
        int p0 = pops;
        fork
            begin
                logic [15:0] x, y;
                for (int i = 0; i < 60; i++) begin
                    x = rand_op();
                    y = rand_op();
                    send(x, y, model(x, y));
                end
                in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (pops - p0 !== 60) begin
            errors++;
            $display("FAIL random_count: %0d outputs required 60", pops - p0);
        end
    endtask

    initial begin
        test_reset();
        test_latency(16'h3C00, 16'h4000, {16'h4000, 4'b0000});
        test_vectors('{16'h3E00, 16'h3C01, 16'h3DA8},
                     '{16'h3E00, 16'h3C01, 16'h3DA8},
                     '{{16'h4080, 4'b0000}, {16'h3C02, 4'b0001}, {16'h4000, 4'b0001}});
        test_vectors('{16'h7BFF, 16'h0400, 16'h8400},
                     '{16'h4000, 16'h3800, 16'h3800},
                     '{{16'h7C00, 4'b0101}, {16'h0000, 4'b0011}, {16'h8000, 4'b0011}});
        test_vectors('{16'h7C00, 16'h7C01, 16'hFC00},
                     '{16'h0000, 16'h3C00, 16'h4000},
                     '{{16'h7E00, 4'b1000}, {16'h7E00, 4'b0000}, {16'hFC00, 4'b0000}});
        test_back_to_back();
        test_reset_flight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
